stride_seq_checker: RTL and testbench

Synthesizable read-side checker for FIFO and CDC datapaths. It consumes the valid/data stream leaving a buffer and verifies it is an arithmetic sequence with a fixed stride, modulo 2^WIDTH. It reports pass/error counts, captures the first mismatch, and flags a stalled stream. It is the consumer-end counterpart of the stride pattern source that drives the FIFO write port, and sits directly on the FIFO's `dout`/`dout_valid` in the read clock domain.

---
 rtl/stride_chk_pkg.sv | 20 ++
 rtl/stride_seq_checker_sat_counter.sv | 25 ++
 rtl/stride_seq_checker.sv | 171 +++++++++++++++++
 tb/tb_stride_seq_checker.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/stride_chk_pkg.sv
// Shared types for the stride sequence checker and the benches that bind to it.
// Latency: n/a (types only).
// Backpressure: n/a.
package stride_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    typedef struct packed {
        logic done;
        logic pass;
        logic err;
        logic timeout;
    } chk_result_t;

endpackage

// File: rtl/stride_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count updates on the edge after inc/clr is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count register: clear first, otherwise increment until saturated.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/stride_seq_checker.sv
// Checks a valid/data stream is an arithmetic sequence of fixed stride (mod 2^WIDTH).
// Latency: counters, flags and captures update one edge after the word is sampled.
// Backpressure: none; every din_valid cycle is consumed, back-to-back supported.
module stride_seq_checker
    import stride_chk_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STRIDE  = 3,
    parameter int CNT_W   = 16,
    parameter int TARGET  = 200,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic             timeout,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] bad_data,
    output logic [WIDTH-1:0] bad_exp
);

    // Stall counter must be able to reach TIMEOUT itself.
    localparam int                 STALL_W    = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]     TGT        = (CNT_W + 1)'(TARGET);
    localparam logic [WIDTH-1:0]   STEP       = WIDTH'(STRIDE);

    chk_state_t         state, state_nxt;
    chk_result_t        res_q;
    logic [WIDTH-1:0]   exp_q;
    logic [STALL_W-1:0] stall_cnt;
    logic [CNT_W:0]     total;
    logic               arm, seed_take, chk_take, match;
    logic               stall_inc, stall_hit, finish;
    logic               pass_inc, err_inc, stall_clr;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle strobes; dropping en always wins and discards the word.
    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        seed_take = 1'b0;
        chk_take  = 1'b0;
        stall_inc = 1'b0;
        match     = (din == exp_q);
        // Count including the word being checked this cycle.
        total     = {1'b0, pass_cnt} + {1'b0, err_cnt} + (CNT_W + 1)'(1);
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    arm       = 1'b1;
                    state_nxt = ST_SEED;
                end
                ST_SEED: begin
                    if (din_valid) begin
                        seed_take = 1'b1;
                        state_nxt = ST_CHECK;
                    end else begin
                        stall_inc = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (din_valid) begin
                        chk_take = 1'b1;
                        if (total == TGT) begin
                            state_nxt = ST_DONE;
                        end
                    end else begin
                        stall_inc = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
        stall_hit = stall_inc && (stall_cnt == STALL_LAST);
        if (stall_hit) begin
            state_nxt = ST_DONE;
        end
        finish = (state_nxt == ST_DONE) && (state != ST_DONE);
    end

    assign pass_inc  = chk_take && match;
    assign err_inc   = chk_take && !match;
    assign stall_clr = arm || seed_take || chk_take;

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (arm),
        .inc  (pass_inc),
        .cnt  (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (arm),
        .inc  (err_inc),
        .cnt  (err_cnt)
    );

    sat_counter #(.W(STALL_W)) u_stall_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (stall_clr),
        .inc  (stall_inc),
        .cnt  (stall_cnt)
    );

    // Expected-word tracking, sticky flags and first-mismatch capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_q    <= '0;
            exp_q    <= '0;
            bad_data <= '0;
            bad_exp  <= '0;
        end else begin
            if (arm) begin
                res_q    <= '0;
                exp_q    <= '0;
                bad_data <= '0;
                bad_exp  <= '0;
            end
            // Resync to the received word even after a mismatch.
            if (seed_take || chk_take) begin
                exp_q <= din + STEP;
            end
            if (err_inc) begin
                res_q.err <= 1'b1;
                if (!res_q.err) begin
                    bad_data <= din;
                    bad_exp  <= exp_q;
                end
            end
            if (stall_hit) begin
                res_q.timeout <= 1'b1;
            end
            if (finish) begin
                res_q.done <= 1'b1;
                res_q.pass <= !(res_q.err || err_inc) && !stall_hit;
            end
        end
    end

    assign done    = res_q.done;
    assign pass    = res_q.pass;
    assign err     = res_q.err;
    assign timeout = res_q.timeout;

endmodule

// File: tb/tb_stride_seq_checker.sv
// Directed bench for stride_seq_checker: table of stream scenarios plus hand-written
// sequences for stall timeout, en drop/re-arm and asynchronous reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_stride_seq_checker;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        din_valid;
    logic [7:0]  din;
    logic        done, pass, err, timeout;
    logic [15:0] pass_cnt, err_cnt;
    logic [7:0]  bad_data, bad_exp;

    int n_tests = 0;
    int n_fail  = 0;

    stride_seq_checker #(
        .WIDTH   (8),
        .STRIDE  (3),
        .CNT_W   (16),
        .TARGET  (200),
        .TIMEOUT (256)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .din_valid (din_valid),
        .din       (din),
        .done      (done),
        .pass      (pass),
        .err       (err),
        .timeout   (timeout),
        .pass_cnt  (pass_cnt),
        .err_cnt   (err_cnt),
        .bad_data  (bad_data),
        .bad_exp   (bad_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] seed;
        int         n_words;
        int         bad_idx;
        logic [7:0] bad_val;
        logic       exp_pass;
        logic       exp_err;
        int         exp_pc;
        int         exp_ec;
        logic [7:0] exp_bd;
        logic [7:0] exp_be;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Caller is at a falling edge; word is sampled on the next rising edge.
    task automatic send_word(input logic [7:0] v);
        din       = v;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic arm_run();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] w;
        arm_run();
        for (int i = 0; i < v.n_words; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w = v.seed + 8'(i * 3);
            if (i == v.bad_idx) w = v.bad_val;
            send_word(w);
            if (i == v.n_words - 2) chk({v.name, ".done_early"}, 32'(done), 32'd0);
            if (i == v.n_words - 1) chk({v.name, ".done_edge"}, 32'(done), 32'd1);
        end
        // Words arriving in DONE must be ignored.
        repeat (3) send_word(8'hC3);
        chk({v.name, ".done"},     32'(done),     32'd1);
        chk({v.name, ".pass"},     32'(pass),     32'(v.exp_pass));
        chk({v.name, ".err"},      32'(err),      32'(v.exp_err));
        chk({v.name, ".timeout"},  32'(timeout),  32'd0);
        chk({v.name, ".pass_cnt"}, 32'(pass_cnt), 32'(v.exp_pc));
        chk({v.name, ".err_cnt"},  32'(err_cnt),  32'(v.exp_ec));
        chk({v.name, ".bad_data"}, 32'(bad_data), 32'(v.exp_bd));
        chk({v.name, ".bad_exp"},  32'(bad_exp),  32'(v.exp_be));
    endtask

    initial begin
        // name, seed, words, bad_idx, bad_val, pass, err, pc, ec, bad_data, bad_exp
        vecs[0] = '{"clean",      8'h00, 201,  -1, 8'h00, 1'b1, 1'b0, 200, 0, 8'h00, 8'h00};
        vecs[1] = '{"corrupt30",  8'h00, 201,  30, 8'h00, 1'b0, 1'b1, 198, 2, 8'h00, 8'h5A};
        vecs[2] = '{"wrap",       8'hFA, 201,  -1, 8'h00, 1'b1, 1'b0, 200, 0, 8'h00, 8'h00};
        vecs[3] = '{"last_bad",   8'h10, 201, 200, 8'hFF, 1'b0, 1'b1, 199, 1, 8'hFF, 8'h68};
        vecs[4] = '{"first_bad",  8'h00, 201,   1, 8'h7E, 1'b0, 1'b1, 198, 2, 8'h7E, 8'h03};

        rstn      = 1'b0;
        en        = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset.outputs", {done, pass, err, timeout, pass_cnt, err_cnt, bad_data, bad_exp} == '0 ? 32'd0 : 32'd1, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) run_vec(vecs[k]);

        // Stall: seed + 4 checked words, then TIMEOUT idle cycles.
        arm_run();
        for (int i = 0; i < 5; i++) send_word(8'(8'h20 + i * 3));
        repeat (255) @(negedge clk);
        chk("stall.done_before", 32'(done),    32'd0);
        chk("stall.to_before",   32'(timeout), 32'd0);
        @(negedge clk);
        chk("stall.done",        32'(done),     32'd1);
        chk("stall.timeout",     32'(timeout),  32'd1);
        chk("stall.pass",        32'(pass),     32'd0);
        chk("stall.err",         32'(err),      32'd0);
        chk("stall.pass_cnt",    32'(pass_cnt), 32'd4);

        // en dropped mid-run: word in the drop cycle ignored, counts held.
        arm_run();
        for (int i = 0; i <= 10; i++) send_word(8'(i * 3));
        chk("endrop.pass_cnt_pre", 32'(pass_cnt), 32'd10);
        en = 1'b0;
        send_word(8'd33);
        repeat (3) send_word(8'h55);
        chk("endrop.pass_cnt_held", 32'(pass_cnt), 32'd10);
        chk("endrop.err_held",      32'(err_cnt),  32'd0);
        chk("endrop.done",          32'(done),     32'd0);
        // Re-arm with a word present: that word must not seed.
        en = 1'b1;
        send_word(8'h99);
        chk("rearm.pass_cnt_clr", 32'(pass_cnt), 32'd0);
        send_word(8'h40);
        send_word(8'h43);
        chk("rearm.pass_cnt", 32'(pass_cnt), 32'd1);
        chk("rearm.err_cnt",  32'(err_cnt),  32'd0);

        // Asynchronous reset between edges while in CHECK with errors recorded.
        arm_run();
        send_word(8'd0);
        send_word(8'd3);
        send_word(8'd99);
        send_word(8'd9);
        chk("arst.pre_err_cnt", 32'(err_cnt), 32'd2);
        #2 rstn = 1'b0;
        #1;
        chk("arst.flags",  32'({done, pass, err, timeout}), 32'd0);
        chk("arst.counts", {pass_cnt, err_cnt},             32'd0);
        chk("arst.capt",   32'({bad_data, bad_exp}),        32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
